// File: rtl/io_bus_initiator.sv
// ============================================================================
// Module      : io_bus_initiator
// Description : Bus-master end of the 8-bit SoC I/O bus. Executes single
//               WRITE / READ / SET / CLR / POLL commands and returns one
//               response per command.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_bus_initiator #(
    parameter int POLL_LIMIT = 16,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic [7:0] cmd_mask,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] io_address,
    output logic [7:0] io_dout,
    output logic       io_w_en,
    output logic       io_r_en,
    input  logic [7:0] io_din
);

    localparam logic [2:0]       c_OP_WRITE  = 3'd0;
    localparam logic [2:0]       c_OP_READ   = 3'd1;
    localparam logic [2:0]       c_OP_SET    = 3'd2;
    localparam logic [2:0]       c_OP_CLR    = 3'd3;
    localparam logic [2:0]       c_OP_POLL   = 3'd4;
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_op;
    logic [7:0]       r_wdata;
    logic [7:0]       r_mask;
    logic [7:0]       r_wr_data;
    logic [7:0]       r_rd;
    logic [CNT_W-1:0] r_cnt;

    logic w_accept;
    logic w_match;
    logic w_poll_done;

    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_match     = ((io_din & r_mask) == (r_wdata & r_mask));
    assign w_poll_done = w_match || (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        c_OP_WRITE:                         w_next = S_WR;
                        c_OP_READ, c_OP_SET, c_OP_CLR,
                        c_OP_POLL:                          w_next = S_RD;
                        default:                            w_next = S_RESP;
                    endcase
                end
            end
            S_RD:   w_next = S_CAP;
            S_CAP: begin
                case (r_op)
                    c_OP_SET, c_OP_CLR: w_next = S_WR;
                    c_OP_POLL:          w_next = w_poll_done ? S_RESP : S_RD;
                    default:            w_next = S_RESP;
                endcase
            end
            S_WR:   w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Response fields only change on the edge that enters RESP, so they hold
    // between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= 3'd0;
            r_wdata    <= 8'h00;
            r_mask     <= 8'h00;
            r_wr_data  <= 8'h00;
            r_rd       <= 8'h00;
            r_cnt      <= '0;
            io_address <= 8'h00;
            rsp_data   <= 8'h00;
            rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= cmd_op;
                io_address <= cmd_addr;
                r_wdata    <= cmd_wdata;
                r_mask     <= cmd_mask;
                r_wr_data  <= cmd_wdata;
                r_cnt      <= '0;
                if (cmd_op > c_OP_POLL) rsp_err <= 1'b1;
            end
            if (r_state == S_CAP) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_rd  <= io_din;
                case (r_op)
                    c_OP_SET: r_wr_data <= io_din | r_wdata;
                    c_OP_CLR: r_wr_data <= io_din & ~r_wdata;
                    c_OP_POLL: begin
                        if (w_poll_done) begin
                            rsp_data <= io_din;
                            rsp_err  <= ~w_match;
                        end
                    end
                    default: begin
                        rsp_data <= io_din;
                        rsp_err  <= 1'b0;
                    end
                endcase
            end
            if (r_state == S_WR) begin
                rsp_data <= (r_op == c_OP_WRITE) ? r_wdata : r_rd;
                rsp_err  <= 1'b0;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign io_w_en   = (r_state == S_WR);
    assign io_r_en   = (r_state == S_RD);
    assign io_dout   = io_w_en ? r_wr_data : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_initiator.sv
// ============================================================================
// Module      : tb_io_bus_initiator
// Description : Self-checking bench for io_bus_initiator with a peripheral
//               model, directed vector table and randomized commands.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_bus_initiator;

    localparam int POLL_LIMIT = 16;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] cmd_mask;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] io_address;
    logic [7:0] io_dout;
    logic       io_w_en;
    logic       io_r_en;
    logic [7:0] io_din;

    int total = 0;
    int bad   = 0;

    io_bus_initiator #(.POLL_LIMIT(POLL_LIMIT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .io_address(io_address), .io_dout(io_dout), .io_w_en(io_w_en),
        .io_r_en(io_r_en), .io_din(io_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral: register file, with address 02 acting as a pin register.
    logic [7:0] mem [256];
    logic [7:0] din_r = 8'h00;
    int         rd2_cnt = 0;
    int         rd2_base = 0;
    logic       pins_mode = 1'b0;
    logic [7:0] pins_lo = 8'h3C;

    always @(posedge clk) begin
        if (io_w_en) mem[io_address] <= io_dout;
        if (io_r_en) begin
            if (io_address == 8'h02) begin
                din_r   <= (pins_mode && (rd2_cnt - rd2_base) >= 3) ? 8'h01 : pins_lo;
                rd2_cnt <= rd2_cnt + 1;
            end else begin
                din_r <= mem[io_address];
            end
        end
    end
    assign io_din = din_r;

    always @(negedge clk) begin
        total++;
        if ((io_w_en && io_r_en) || (!io_w_en && io_dout != 8'h00)) begin
            bad++;
            $display("FAIL invariant: w_en=%0b r_en=%0b dout=%0h, required exclusive strobes and dout=0 when idle",
                     io_w_en, io_r_en, io_dout);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] w,
                          input logic [7:0] m, output logic [7:0] d, output logic e,
                          output int lat, output int nr, output int nw,
                          output logic [7:0] ra, output logic [7:0] wa, output logic [7:0] wv);
        int guard;
        d = 8'h00; e = 1'b0; lat = 0; nr = 0; nw = 0; ra = 8'h00; wa = 8'h00; wv = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = w; cmd_mask = m;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (io_r_en) begin nr++; ra = io_address; end
            if (io_w_en) begin nw++; wa = io_address; wv = io_dout; end
            if (rsp_valid) begin
                lat = k; d = rsp_data; e = rsp_err;
                break;
            end
        end
    endtask

    task automatic run_chk(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] w, input logic [7:0] m, input logic [7:0] ed,
                           input logic ee, input int elat, input int enr, input int enw,
                           input logic [7:0] ewv);
        logic [7:0] d, ra, wa, wv;
        logic       e;
        int         lat, nr, nw;
        do_cmd(op, a, w, m, d, e, lat, nr, nw, ra, wa, wv);
        chk($sformatf("%s latency", tag), lat, elat);
        chk($sformatf("%s data", tag), {24'd0, d}, {24'd0, ed});
        chk($sformatf("%s err", tag), {31'd0, e}, {31'd0, ee});
        chk($sformatf("%s reads", tag), nr, enr);
        chk($sformatf("%s writes", tag), nw, enw);
        if (enr > 0) chk($sformatf("%s read addr", tag), {24'd0, ra}, {24'd0, a});
        if (enw > 0) begin
            chk($sformatf("%s write addr", tag), {24'd0, wa}, {24'd0, a});
            chk($sformatf("%s write data", tag), {24'd0, wv}, {24'd0, ewv});
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, w, m, ed;
        logic       ee;
        int         lat, nr, nw;
        logic [7:0] wv;
    } vec_t;

    vec_t       tbl [10];
    logic [7:0] ref_mem [256];
    logic [7:0] last_rsp;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0;
        cmd_addr = 8'h00; cmd_wdata = 8'h00; cmd_mask = 8'h00;
        #2;
        chk("reset w_en", {31'd0, io_w_en}, 32'd0);
        chk("reset r_en", {31'd0, io_r_en}, 32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("reset addr", {24'd0, io_address}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset ready", {31'd0, cmd_ready}, 32'd1);

        // op, addr, wdata, mask, rsp_data, err, latency, reads, writes, write value
        tbl[0] = '{3'd0, 8'h01, 8'hA5, 8'h00, 8'hA5, 1'b0, 2, 0, 1, 8'hA5};
        tbl[1] = '{3'd1, 8'h02, 8'h00, 8'h00, 8'h3C, 1'b0, 3, 1, 0, 8'h00};
        tbl[2] = '{3'd0, 8'h05, 8'h10, 8'h00, 8'h10, 1'b0, 2, 0, 1, 8'h10};
        tbl[3] = '{3'd2, 8'h05, 8'h81, 8'h00, 8'h10, 1'b0, 4, 1, 1, 8'h91};
        tbl[4] = '{3'd3, 8'h05, 8'h10, 8'h00, 8'h91, 1'b0, 4, 1, 1, 8'h81};
        tbl[5] = '{3'd1, 8'h05, 8'h00, 8'h00, 8'h81, 1'b0, 3, 1, 0, 8'h00};
        tbl[6] = '{3'd4, 8'h05, 8'hFF, 8'h00, 8'h81, 1'b0, 3, 1, 0, 8'h00};
        tbl[7] = '{3'd7, 8'h05, 8'h00, 8'h00, 8'h81, 1'b1, 1, 0, 0, 8'h00};
        tbl[8] = '{3'd5, 8'h09, 8'h33, 8'hFF, 8'h81, 1'b1, 1, 0, 0, 8'h00};
        tbl[9] = '{3'd1, 8'h01, 8'h00, 8'h00, 8'hA5, 1'b0, 3, 1, 0, 8'h00};
        for (int i = 0; i < 10; i++)
            run_chk($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].w, tbl[i].m,
                    tbl[i].ed, tbl[i].ee, tbl[i].lat, tbl[i].nr, tbl[i].nw, tbl[i].wv);

        // POLL: bit0 of the pins rises after three reads.
        pins_lo = 8'h00; pins_mode = 1'b1; rd2_base = rd2_cnt;
        run_chk("poll_rise", 3'd4, 8'h02, 8'h01, 8'h01, 8'h01, 1'b0, 9, 4, 0, 8'h00);
        // POLL: pins stuck low, times out after POLL_LIMIT reads.
        pins_mode = 1'b0;
        run_chk("poll_stuck", 3'd4, 8'h02, 8'h01, 8'h01, 8'h00, 1'b1,
                2 * POLL_LIMIT + 1, POLL_LIMIT, 0, 8'h00);

        // Back-to-back: READ then WRITE with cmd_valid held high.
        begin
            int seen = 0;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 8'h01; cmd_wdata = 8'h00; cmd_mask = 8'h00;
            for (int k = 0; k < 20 && seen == 0; k++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    seen = 1;
                    chk("b2b read data", {24'd0, rsp_data}, 32'hA5);
                    cmd_op = 3'd0; cmd_addr = 8'h06; cmd_wdata = 8'h5A;
                end
            end
            chk("b2b read rsp", seen, 1);
            @(negedge clk);
            chk("b2b ready after rsp", {31'd0, cmd_ready}, 32'd1);
            @(negedge clk);
            chk("b2b w_en", {31'd0, io_w_en}, 32'd1);
            chk("b2b w addr", {24'd0, io_address}, 32'h06);
            chk("b2b w data", {24'd0, io_dout}, 32'h5A);
            cmd_valid = 1'b0;
            @(negedge clk);
            chk("b2b write rsp", {31'd0, rsp_valid}, 32'd1);
            chk("b2b write data", {24'd0, rsp_data}, 32'h5A);
        end

        // Reset in the middle of a POLL while io_r_en is high.
        begin
            int nrd = 0;
            int hits = 0;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 3'd4; cmd_addr = 8'h02; cmd_wdata = 8'h01; cmd_mask = 8'h01;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            for (int k = 0; k < 40 && nrd < 3; k++) begin
                @(negedge clk);
                if (io_r_en) nrd++;
            end
            chk("mid-poll r_en seen", nrd, 3);
            chk("mid-poll r_en before reset", {31'd0, io_r_en}, 32'd1);
            rst_n = 1'b0;
            #1;
            chk("mid-poll r_en drop", {31'd0, io_r_en}, 32'd0);
            chk("mid-poll rsp_valid", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (rsp_valid || io_r_en || io_w_en) hits++;
            end
            chk("post-reset quiet", hits, 0);
            chk("post-reset ready", {31'd0, cmd_ready}, 32'd1);
            chk("post-reset rsp_data", {24'd0, rsp_data}, 32'd0);
            chk("post-reset addr", {24'd0, io_address}, 32'd0);
        end

        // Randomized commands against a reference model of the register file.
        for (int i = 0; i < 16; i++) begin
            if (i != 2) begin
                logic [7:0] v = 8'($urandom);
                run_chk($sformatf("pre%0d", i), 3'd0, 8'(i), v, 8'h00, v, 1'b0, 2, 0, 1, v);
                ref_mem[i] = v;
                last_rsp = v;
            end
        end
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op = 3'($urandom_range(0, 7));
            logic [7:0] a  = 8'($urandom_range(0, 15));
            logic [7:0] w  = 8'($urandom);
            logic [7:0] m  = 8'($urandom);
            logic [7:0] ed, ewv;
            logic       ee;
            int         elat, enr, enw;
            if (a == 8'h02) a = 8'h03;
            ee = 1'b0; ewv = 8'h00; enr = 0; enw = 0;
            case (op)
                3'd0: begin ed = w; elat = 2; enw = 1; ewv = w; end
                3'd1: begin ed = ref_mem[a]; elat = 3; enr = 1; end
                3'd2: begin ed = ref_mem[a]; elat = 4; enr = 1; enw = 1; ewv = ref_mem[a] | w; end
                3'd3: begin ed = ref_mem[a]; elat = 4; enr = 1; enw = 1; ewv = ref_mem[a] & ~w; end
                3'd4: begin
                    if ($urandom_range(0, 1) == 1) w = ref_mem[a] ^ (w & ~m);
                    ed = ref_mem[a];
                    if ((ref_mem[a] & m) == (w & m)) begin elat = 3; enr = 1; end
                    else begin elat = 2 * POLL_LIMIT + 1; enr = POLL_LIMIT; ee = 1'b1; end
                end
                default: begin ed = last_rsp; ee = 1'b1; elat = 1; end
            endcase
            run_chk($sformatf("rnd%0d", i), op, a, w, m, ed, ee, elat, enr, enw, ewv);
            if (enw > 0) ref_mem[a] = ewv;
            last_rsp = ed;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
